// File: rtl/eaglesong_bit_matrix_mix.sv
// eaglesong_bit_matrix_mix
//
// Sequential Eaglesong theta (linear mixing) engine. A 16 x 32-bit state is
// multiplied by the fixed 16x16 Eaglesong bit matrix over GF(2):
//   out[j] = XOR_k ( M[k][j] ? in[k] : 0 )
// LANES output words are produced per COMPUTE cycle, so one job takes
// 16/LANES COMPUTE cycles followed by a DONE cycle held until out_ready.
//
// Optional feature macro: EAGLESONG_BIT_MATRIX_READ_PORT_EN
//   defined   -> requested_bit is a registered read of M[bit_index_to_request]
//   undefined -> requested_bit is tied low, bit_index_to_request is ignored
// The mixing datapath is identical in both builds.

module eaglesong_bit_matrix_mix #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_state,
  input  logic [7:0]   bit_index_to_request,
  output logic         requested_bit
);

  // Number of COMPUTE cycles per job and the lane-group counter width.
  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

  // Only power-of-two lane counts that divide the 16 words are supported.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_illegal
    $error("eaglesong_bit_matrix_mix: LANES must be 1, 2, 4, 8 or 16");
  end

  // Eaglesong bit matrix. Bit index k*16+j holds M[k][j]; each 16-bit
  // literal below is one row k written column 15 down to column 0.
  localparam logic [255:0] MATRIX = {
    16'b1101010110110010,  // row 15
    16'b0111101011011001,  // row 14
    16'b1011110101101100,  // row 13
    16'b0101111010110110,  // row 12
    16'b0010111101011011,  // row 11
    16'b1001011110101101,  // row 10
    16'b1100101111010110,  // row 9
    16'b0110010111101011,  // row 8
    16'b1000000001000100,  // row 7
    16'b1100000000100010,  // row 6
    16'b1110000000010001,  // row 5
    16'b0111010101011111,  // row 4
    16'b1111110101111000,  // row 3
    16'b1011111010111100,  // row 2
    16'b1001111101011110,  // row 1
    16'b1000111110101111   // row 0
  };

  // FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Matrix coefficient M[row][col]; the {row,col} concatenation is the
  // flat bit index into MATRIX.
  function automatic logic matrix_bit(input logic [3:0] row, input logic [3:0] col);
    return MATRIX[{row, col}];
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [511:0]  in_q, in_d;
  logic [511:0]  out_q, out_d;
  logic [511:0]  mix_s;
  logic [3:0]    col_s;
  logic [31:0]   acc_s;

  // Mix the captured state into the LANES output words selected by cnt_q;
  // words outside the current lane group keep their previous contents.
  always_comb begin
    mix_s = out_q;
    col_s = 4'd0;
    acc_s = 32'd0;
    for (int l = 0; l < LANES; l++) begin
      col_s = 4'(32'(cnt_q) * LANES + l);
      acc_s = 32'd0;
      for (int k = 0; k < 16; k++) begin
        if (matrix_bit(4'(k), col_s)) begin
          acc_s = acc_s ^ in_q[32*k +: 32];
        end else begin
          acc_s = acc_s;
        end
      end
      mix_s[32*col_s +: 32] = acc_s;
    end
  end

  // Next-state logic for the IDLE -> COMPUTE -> DONE job sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          in_d    = in_state;
          cnt_d   = {CW{1'b0}};
          state_d = ST_COMPUTE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        out_d = mix_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CW{1'b0}};
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State, counter, captured input and output registers; reset aborts any job.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      in_q    <= 512'd0;
      out_q   <= 512'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      out_q   <= out_d;
    end
  end

  // Handshake outputs decode only registered state (and reset_n for in_ready).
  assign in_ready  = reset_n & (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_state = out_q;

`ifdef EAGLESONG_BIT_MATRIX_READ_PORT_EN
  logic requested_bit_q;

  // Registered debug read of the matrix, independent of the FSM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      requested_bit_q <= 1'b0;
    end else begin
      requested_bit_q <= MATRIX[bit_index_to_request];
    end
  end

  assign requested_bit = requested_bit_q;
`else
  logic unused_bit_index_s;

  assign unused_bit_index_s = ^bit_index_to_request;
  assign requested_bit      = 1'b0;
`endif

endmodule

// File: tb/tb_eaglesong_bit_matrix_mix.sv
// tb_eaglesong_bit_matrix_mix
//
// Instantiates the mixer for LANES = 1, 2, 4, 8, 16 side by side and checks
// each against a reference built from the matrix rows written as text.
// Read-port expectations follow EAGLESONG_BIT_MATRIX_READ_PORT_EN.

module tb_eaglesong_bit_matrix_mix;

  localparam int NDUT = 5;
  localparam int LANES_TAB [NDUT] = '{1, 2, 4, 8, 16};

  // Row k, character j is M[k][j] (column 0 first).
  string mrows [16] = '{
    "1111010111110001",
    "0111101011111001",
    "0011110101111101",
    "0001111010111111",
    "1111101010101110",
    "1000100000000111",
    "0100010000000011",
    "0010001000000001",
    "1101011110100110",
    "0110101111010011",
    "1011010111101001",
    "1101101011110100",
    "0110110101111010",
    "0011011010111101",
    "1001101101011110",
    "0100110110101011"
  };

  logic         clk;
  logic         reset_n;
  logic [7:0]   bit_idx;
  logic         in_valid  [NDUT];
  logic [511:0] in_state  [NDUT];
  logic         out_ready [NDUT];
  wire          in_ready_w  [NDUT];
  wire          out_valid_w [NDUT];
  wire  [511:0] out_state_w [NDUT];
  wire          req_bit_w   [NDUT];

  int n_vec;
  int n_err;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    eaglesong_bit_matrix_mix #(.LANES(LANES_TAB[g])) u_dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .in_valid             (in_valid[g]),
      .in_ready             (in_ready_w[g]),
      .in_state             (in_state[g]),
      .out_valid            (out_valid_w[g]),
      .out_ready            (out_ready[g]),
      .out_state            (out_state_w[g]),
      .bit_index_to_request (bit_idx),
      .requested_bit        (req_bit_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic mbit(input int k, input int j);
    return (mrows[k][j] == 8'h31);
  endfunction

  // out[j] = XOR of in[k] over rows k whose column j is set.
  function automatic logic [511:0] ref_mix(input logic [511:0] s);
    logic [511:0] r;
    r = '0;
    for (int j = 0; j < 16; j++)
      for (int k = 0; k < 16; k++)
        if (mbit(k, j)) r[32*j +: 32] = r[32*j +: 32] ^ s[32*k +: 32];
    return r;
  endfunction

  function automatic logic [511:0] rand_state();
    logic [511:0] r;
    for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Present a state until accepted, then wait (bounded) for out_valid.
  task automatic run_job(input int g, input logic [511:0] st,
                         output logic [511:0] res, output int lat);
    int tries;
    @(negedge clk);
    in_valid[g] = 1'b1;
    in_state[g] = st;
    tries = 0;
    while (!in_ready_w[g] && tries < 40) begin
      @(negedge clk);
      tries++;
    end
    chk("ready_seen", 512'(in_ready_w[g]), 512'd1);
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    in_state[g] = rand_state();  // must not disturb the running job
    lat = 0;
    while (!out_valid_w[g] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done_seen", 512'(out_valid_w[g]), 512'd1);
    res = out_state_w[g];
  endtask

  initial begin
    logic [511:0] st, a, b, ra, rb, rab, res;
    int lat;
    int idx_tab [7];
    logic exp_bit;

    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    bit_idx = 8'd0;
    for (int g = 0; g < NDUT; g++) begin
      in_valid[g]  = 1'b0;
      in_state[g]  = '0;
      out_ready[g] = 1'b1;
    end

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      chk("rst_out_valid", 512'(out_valid_w[g]), 512'd0);
      chk("rst_in_ready",  512'(in_ready_w[g]),  512'd0);
      chk("rst_out_state", out_state_w[g],       512'd0);
      chk("rst_req_bit",   512'(req_bit_w[g]),   512'd0);
    end
    reset_n = 1'b1;
    #1;
    for (int g = 0; g < NDUT; g++) chk("idle_in_ready", 512'(in_ready_w[g]), 512'd1);

    // Identity probe, LANES = 4
    st = '0;
    st[31:0] = 32'h0000_0001;
    run_job(2, st, res, lat);
    chk("id_latency", 512'(lat), 512'd4);
    chk("id_word0", 512'(res[31:0]),  512'h1);
    chk("id_word2", 512'(res[95:64]), 512'h1);
    chk("id_full", res, ref_mix(st));

    // Row-15 probe
    st = '0;
    st[511:480] = 32'hFFFF_FFFF;
    run_job(2, st, res, lat);
    chk("r15_word13", 512'(res[32*13 +: 32]), 512'd0);
    chk("r15_full", res, ref_mix(st));

    // Linearity and latency for every lane count
    for (int g = 0; g < NDUT; g++) begin
      a = rand_state();
      b = rand_state();
      run_job(g, a, ra, lat);
      chk("lin_lat_a", 512'(lat), 512'(16 / LANES_TAB[g]));
      chk("lin_a", ra, ref_mix(a));
      run_job(g, b, rb, lat);
      chk("lin_lat_b", 512'(lat), 512'(16 / LANES_TAB[g]));
      chk("lin_b", rb, ref_mix(b));
      run_job(g, a ^ b, rab, lat);
      chk("lin_lat_ab", 512'(lat), 512'(16 / LANES_TAB[g]));
      chk("lin_xor", rab, ref_mix(a) ^ ref_mix(b));
    end

    // Backpressure, LANES = 4
    a = rand_state();
    b = rand_state();
    out_ready[2] = 1'b0;
    run_job(2, a, res, lat);
    chk("bp_first", res, ref_mix(a));
    @(negedge clk);
    in_valid[2] = 1'b1;
    in_state[2] = b;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_state", out_state_w[2], ref_mix(a));
      chk("bp_in_ready",   512'(in_ready_w[2]),  512'd0);
      chk("bp_out_valid",  512'(out_valid_w[2]), 512'd1);
    end
    @(negedge clk);
    out_ready[2] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_ready", 512'(in_ready_w[2]),  512'd1);
    chk("bp_release_valid", 512'(out_valid_w[2]), 512'd0);
    @(posedge clk);
    #1;
    chk("bp_second_taken", 512'(in_ready_w[2]), 512'd0);
    in_valid[2] = 1'b0;
    lat = 0;
    while (!out_valid_w[2] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_second_lat", 512'(lat), 512'd4);
    chk("bp_second", out_state_w[2], ref_mix(b));

    // Abort in the second COMPUTE cycle, LANES = 2
    a = rand_state();
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_state[1] = a;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("ab_mid_valid", 512'(out_valid_w[1]), 512'd0);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("ab_out_valid", 512'(out_valid_w[1]), 512'd0);
    chk("ab_out_state", out_state_w[1],       512'd0);
    chk("ab_in_ready",  512'(in_ready_w[1]),  512'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ab_idle", 512'(in_ready_w[1]), 512'd1);
    b = rand_state();
    run_job(1, b, res, lat);
    chk("ab_fresh_lat", 512'(lat), 512'd8);
    chk("ab_fresh", res, ref_mix(b));

    // Matrix read port
    idx_tab = '{0, 2, 253, 17, 80, 255, 130};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bit_idx = 8'(idx_tab[i]);
      @(posedge clk);
      #1;
`ifdef EAGLESONG_BIT_MATRIX_READ_PORT_EN
      exp_bit = mbit(idx_tab[i] / 16, idx_tab[i] % 16);
`else
      exp_bit = 1'b0;
`endif
      chk("read_port", 512'(req_bit_w[0]), 512'(exp_bit));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
